digit_window_scroller: RTL

DIGIT_WINDOW_SCROLLER -- requirements
Module: digit_window_scroller

---
 rtl/digit_window_scroller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/digit_window_scroller.sv
// digit_window_scroller: shows a WIN_DIGITS-wide window onto a NUM_DIGITS BCD
// value, scrolled one digit at a time by two debounced push buttons.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   bcd        packed BCD value, digit 0 in bits [3:0] (least significant)
//   btn_left   raw button, press scrolls toward more-significant digits
//   btn_right  raw button, press scrolls toward less-significant digits
//   window     displayed digits, window digit 0 in bits [3:0] (rightmost);
//              4'hF is the blank code for suppressed leading zeros
//   offset     bcd digit index shown in window digit 0
//   at_right   offset is 0
//   at_left    offset is at its maximum
module digit_window_scroller #(
  parameter int unsigned NUM_DIGITS      = 5,
  parameter int unsigned WIN_DIGITS      = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BLANK_LZ        = 1,
  localparam int unsigned MAX_OFF = NUM_DIGITS - WIN_DIGITS,
  localparam int unsigned OFF_W   = (MAX_OFF < 1) ? 1 : $clog2(MAX_OFF + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic                    btn_left,
  input  logic                    btn_right,
  output logic [4*WIN_DIGITS-1:0] window,
  output logic [OFF_W-1:0]        offset,
  output logic                    at_right,
  output logic                    at_left
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NBTN  = 2;
  localparam int unsigned B_L   = 0;
  localparam int unsigned B_R   = 1;

  logic [NBTN-1:0]  btn_raw;
  logic [NBTN-1:0]  sync1;
  logic [NBTN-1:0]  sync2;
  logic [NBTN-1:0]  lvl;
  logic [NBTN-1:0]  lvl_d;
  logic [CNT_W-1:0] cnt [NBTN];
  logic [NBTN-1:0]  step;
  logic [OFF_W-1:0] offset_nxt;

  int unsigned msd;
  int unsigned idx;
  logic [3:0]  dig;

  assign btn_raw = {btn_right, btn_left};

  // Synchronizers, debouncers and registered edge detect for both buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      for (int b = 0; b < NBTN; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      lvl_d <= lvl;
      for (int b = 0; b < NBTN; b++) begin
        if (sync2[b] == lvl[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          // this edge would bring the count to DEBOUNCE_CYCLES: accept level
          lvl[b] <= ~lvl[b];
          cnt[b] <= '0;
        end else begin
          cnt[b] <= cnt[b] + 1'b1;
        end
      end
    end
  end

  // One-cycle pulse on each accepted press; releases produce nothing.
  assign step = lvl & ~lvl_d;

  // Offset state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset <= '0;
    end else begin
      offset <= offset_nxt;
    end
  end

  // Saturating scroll; simultaneous pulses cancel.
  always_comb begin
    offset_nxt = offset;
    if (step[B_L] && !step[B_R] && (offset != OFF_W'(MAX_OFF))) begin
      offset_nxt = offset + 1'b1;
    end else if (step[B_R] && !step[B_L] && (offset != '0)) begin
      offset_nxt = offset - 1'b1;
    end
  end

  assign at_right = (offset == '0);
  assign at_left  = (offset == OFF_W'(MAX_OFF));

  // Window select with leading-zero blanking; digit 0 is never blank.
  always_comb begin
    msd    = 0;
    idx    = 0;
    dig    = 4'h0;
    window = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd[4*d +: 4] != 4'h0) begin
        msd = d;
      end
    end
    for (int i = 0; i < WIN_DIGITS; i++) begin
      idx = 32'(offset) + 32'(i);
      dig = bcd[4*idx +: 4];
      if ((BLANK_LZ != 0) && (idx > msd)) begin
        dig = 4'hF;
      end
      window[4*i +: 4] = dig;
    end
  end

endmodule
